// File: rtl/register_writeback_queue_if.sv
// register_writeback_queue_if: even/odd result channels, register-file write port and forwarding query
interface register_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic              even_valid;
  logic              even_ready;
  logic [ADDR_W-1:0] even_rt;
  logic [DATA_W-1:0] even_data;
  logic              odd_valid;
  logic              odd_ready;
  logic [ADDR_W-1:0] odd_rt;
  logic [DATA_W-1:0] odd_data;
  logic              flush;
  logic              regWriteEnable;
  logic [ADDR_W-1:0] writeRegisterRT;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] fwd_reg;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  modport master (
    output even_valid, even_rt, even_data, odd_valid, odd_rt, odd_data, flush, fwd_reg,
    input  even_ready, odd_ready, regWriteEnable, writeRegisterRT, writeData, count, full, empty,
           fwd_hit, fwd_data
  );
  modport slave (
    input  even_valid, even_rt, even_data, odd_valid, odd_rt, odd_data, flush, fwd_reg,
    output even_ready, odd_ready, regWriteEnable, writeRegisterRT, writeData, count, full, empty,
           fwd_hit, fwd_data
  );
endinterface

// File: rtl/register_writeback_queue.sv
// register_writeback_queue: in-order dual-push FIFO feeding one register-file write per clock; REG_WB_FWD_EN enables pending-result forwarding
module register_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input logic clk,
  input logic reset,
  register_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ADDR_W-1:0] rtMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;
  logic              wbValid;
  logic [ADDR_W-1:0] wbRt;
  logic [DATA_W-1:0] wbData;
  logic              evenPush, oddPush, pop;
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;
  // Ready depends only on current occupancy, never on this cycle's pop
  assign bus.even_ready = count < CNT_W'(DEPTH);
  assign bus.odd_ready  = (count + CNT_W'(bus.even_valid & bus.even_ready)) < CNT_W'(DEPTH);
  assign evenPush = bus.even_valid & bus.even_ready & ~bus.flush;
  assign oddPush  = bus.odd_valid & bus.odd_ready & ~bus.flush;
  assign pop      = count != '0;
  assign bus.count           = count;
  assign bus.full            = count == CNT_W'(DEPTH);
  assign bus.empty           = count == '0;
  assign bus.regWriteEnable  = wbValid;
  assign bus.writeRegisterRT = wbRt;
  assign bus.writeData       = wbData;
  assign bus.fwd_hit         = fwdHit;
  assign bus.fwd_data        = fwdData;
  // Storage: even entry takes the tail slot, odd lands just behind it when both are accepted
  always_ff @(posedge clk) begin
    if (evenPush) begin
      rtMem[wrPtr]   <= bus.even_rt;
      dataMem[wrPtr] <= bus.even_data;
    end
    if (oddPush) begin
      rtMem[wrPtr + PTR_W'(evenPush)]   <= bus.odd_rt;
      dataMem[wrPtr + PTR_W'(evenPush)] <= bus.odd_data;
    end
  end
  // Pointers, occupancy and the registered write port; flush discards everything including this cycle's inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      wbValid <= 1'b0;
      wbRt    <= '0;
      wbData  <= '0;
    end else if (bus.flush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      wbValid <= 1'b0;
    end else begin
      wrPtr   <= wrPtr + PTR_W'(evenPush) + PTR_W'(oddPush);
      rdPtr   <= rdPtr + PTR_W'(pop);
      count   <= count + CNT_W'(evenPush) + CNT_W'(oddPush) - CNT_W'(pop);
      wbValid <= pop;
      if (pop) begin
        wbRt   <= rtMem[rdPtr];
        wbData <= dataMem[rdPtr];
      end
    end
  end
`ifdef REG_WB_FWD_EN
  // Forwarding: output stage is the weakest match, each younger FIFO entry overrides older ones
  always_comb begin
    fwdHit  = wbValid && wbRt == bus.fwd_reg;
    fwdData = fwdHit ? wbData : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && rtMem[rdPtr + PTR_W'(i)] == bus.fwd_reg) begin
        fwdHit  = 1'b1;
        fwdData = dataMem[rdPtr + PTR_W'(i)];
      end
    end
  end
`else
  assign fwdHit  = 1'b0;
  assign fwdData = '0;
`endif
endmodule

// File: tb/tb_register_writeback_queue.sv
// tb_register_writeback_queue: directed and randomized checks against a queue-based reference model
module tb_register_writeback_queue;
  localparam int DEPTH = 4;
  typedef struct { logic [6:0] rt; logic [127:0] data; } entry_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  entry_t q[$];
  logic expWe = 1'b0;
  logic [6:0] expRt = '0;
  logic [127:0] expData = '0;
  register_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(128)) bus();
  register_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(128)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chkOutputs(input string tag);
    chk({tag, ".regWriteEnable"}, bus.regWriteEnable, expWe);
    chk({tag, ".writeRegisterRT"}, bus.writeRegisterRT, expRt);
    chk({tag, ".writeData"}, bus.writeData, expData);
    chk({tag, ".count"}, bus.count, q.size());
    chk({tag, ".full"}, bus.full, q.size() == DEPTH);
    chk({tag, ".empty"}, bus.empty, q.size() == 0);
  endtask
  task automatic step(input logic ev, input logic [6:0] ert, input logic [127:0] ed,
                      input logic ov, input logic [6:0] ort, input logic [127:0] od,
                      input logic fl, input logic [6:0] freg);
    logic er, orr, eh;
    logic [127:0] efd;
    entry_t h;
    bus.even_valid = ev; bus.even_rt = ert; bus.even_data = ed;
    bus.odd_valid = ov; bus.odd_rt = ort; bus.odd_data = od;
    bus.flush = fl; bus.fwd_reg = freg;
    #1;
    er  = q.size() < DEPTH;
    orr = (q.size() + int'(ev && er)) < DEPTH;
    chk("even_ready", bus.even_ready, er);
    chk("odd_ready", bus.odd_ready, orr);
    eh = 1'b0;
    efd = '0;
`ifdef REG_WB_FWD_EN
    for (int i = q.size() - 1; i >= 0; i--)
      if (!eh && q[i].rt == freg) begin eh = 1'b1; efd = q[i].data; end
    if (!eh && expWe && expRt == freg) begin eh = 1'b1; efd = expData; end
    chk("fwd_hit", bus.fwd_hit, eh);
    if (eh) chk("fwd_data", bus.fwd_data, efd);
`else
    chk("fwd_hit", bus.fwd_hit, eh);
    chk("fwd_data", bus.fwd_data, efd);
`endif
    if (fl) begin
      q.delete();
      expWe = 1'b0;
    end else begin
      expWe = q.size() != 0;
      if (expWe) begin h = q.pop_front(); expRt = h.rt; expData = h.data; end
      if (ev && er) q.push_back('{ert, ed});
      if (ov && orr) q.push_back('{ort, od});
    end
    @(posedge clk);
    #1;
    chkOutputs("edge");
  endtask
  task automatic idle(input logic [6:0] freg);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, freg);
  endtask
  task automatic applyReset();
    bus.even_valid = 1'b0; bus.odd_valid = 1'b0; bus.flush = 1'b0;
    reset = 1'b0;
    #1;
    q.delete();
    expWe = 1'b0; expRt = '0; expData = '0;
    chkOutputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chkOutputs("post_reset");
  endtask
  initial begin
    bus.even_valid = 1'b0; bus.even_rt = '0; bus.even_data = '0;
    bus.odd_valid = 1'b0; bus.odd_rt = '0; bus.odd_data = '0;
    bus.flush = 1'b0; bus.fwd_reg = '0;
    #2;
    applyReset();
    step(1'b1, 7'd2, 128'd54, 1'b0, '0, '0, 1'b0, '0);
    chk("t1.we_not_yet", bus.regWriteEnable, 1'b0);
    idle('0);
    chk("t1.we", bus.regWriteEnable, 1'b1);
    chk("t1.rt", bus.writeRegisterRT, 7'd2);
    chk("t1.data", bus.writeData, 128'd54);
    idle('0);
    chk("t1.we_drop", bus.regWriteEnable, 1'b0);
    step(1'b1, 7'd5, 128'd10, 1'b1, 7'd6, 128'd20, 1'b0, '0);
    idle('0);
    chk("t2.first_rt", bus.writeRegisterRT, 7'd5);
    idle('0);
    chk("t2.second_rt", bus.writeRegisterRT, 7'd6);
    idle('0);
    for (int i = 0; i < 3; i++) step(1'b1, 7'(10 + i), 128'(i), 1'b1, 7'(20 + i), 128'(100 + i), 1'b0, '0);
    chk("t3.count3", bus.count, 3'd3);
    bus.even_valid = 1'b1; bus.odd_valid = 1'b1;
    #1;
    chk("t3.even_ready", bus.even_ready, 1'b1);
    chk("t3.odd_ready", bus.odd_ready, 1'b0);
    step(1'b1, 7'd30, 128'd300, 1'b1, 7'd31, 128'd301, 1'b1, '0);
    chk("t4.count", bus.count, 3'd0);
    chk("t4.empty", bus.empty, 1'b1);
    chk("t4.we", bus.regWriteEnable, 1'b0);
    idle('0);
    chk("t4.no_stale", bus.regWriteEnable, 1'b0);
    step(1'b1, 7'd9, 128'd1, 1'b1, 7'd9, 128'd2, 1'b0, 7'd9);
    bus.even_valid = 1'b0; bus.odd_valid = 1'b0; bus.fwd_reg = 7'd9;
    #1;
`ifdef REG_WB_FWD_EN
    chk("t5.hit9", bus.fwd_hit, 1'b1);
    chk("t5.data9", bus.fwd_data, 128'd2);
`else
    chk("t5.hit9_off", bus.fwd_hit, 1'b0);
`endif
    bus.fwd_reg = 7'd10;
    #1;
    chk("t5.hit10", bus.fwd_hit, 1'b0);
    idle(7'd9);
    step(1'b1, 7'd40, 128'd400, 1'b1, 7'd41, 128'd401, 1'b0, '0);
    applyReset();
    idle('0);
    chk("t6.no_write", bus.regWriteEnable, 1'b0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) applyReset();
      step($urandom_range(3) != 0, 7'($urandom_range(7)), {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(3) != 0, 7'($urandom_range(7)), {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(15) == 0, 7'($urandom_range(7)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
